// File: rtl/qarctan_iter.sv
`default_nettype none
// ============================================================================
// Module  : qarctan_iter
// Brief   : Quantised arctangent with a built-in restoring divider and FIFO ports.
// Revision: 1.0
// ============================================================================
module qarctan_iter #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 10,
  parameter int QUAD1      = 804,
  parameter int QUAD3      = 2412,
  parameter int TAG_WIDTH  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  in_y_rd_en,
  input  logic                  in_y_empty,
  input  logic [DATA_WIDTH-1:0] in_y_dout,
  output logic                  in_x_rd_en,
  input  logic                  in_x_empty,
  input  logic [DATA_WIDTH-1:0] in_x_dout,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_wr_en,
  input  logic                  out_full,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  busy
);

  localparam int W  = DATA_WIDTH + 2;
  localparam int MW = W + FRAC_BITS;
  localparam int QW = FRAC_BITS + 1;
  localparam int CW = $clog2(FRAC_BITS + 2);
  localparam logic signed [MW-1:0] C_QUAD1 = MW'(QUAD1);
  localparam logic signed [MW-1:0] C_QUAD3 = MW'(QUAD3);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIV   = 2'd1,
    S_SCALE = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [MW-1:0]         rem_q, rem_d;
  logic [MW-1:0]         div_q, div_d;
  logic [QW-1:0]         quo_q, quo_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  num_neg_q, num_neg_d;
  logic                  x_neg_q, x_neg_d;
  logic                  y_neg_q, y_neg_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;
  logic [DATA_WIDTH-1:0] out_din_q, out_din_d;

  // Operand formatting: two guard bits keep |y|+1 and x+|y|+1 exact at the extremes.
  logic signed [W-1:0] y_ext, x_ext, abs_y, sum, den;
  logic        [W-1:0] sum_mag;

  always_comb begin
    y_ext = {{2{in_y_dout[DATA_WIDTH-1]}}, in_y_dout};
    x_ext = {{2{in_x_dout[DATA_WIDTH-1]}}, in_x_dout};
    abs_y = (y_ext[W-1] ? -y_ext : y_ext) + W'(1);
    if (!x_ext[W-1]) begin
      sum = x_ext - abs_y;
      den = x_ext + abs_y;
    end else begin
      sum = x_ext + abs_y;
      den = abs_y - x_ext;
    end
    sum_mag = sum[W-1] ? -sum : sum;
  end

  // Signed quotient, scale by QUAD1, divide by 2^FRAC_BITS truncating toward zero.
  logic signed [MW-1:0] r_s, p_s, p_mag, d_s, ang_s;

  always_comb begin
    r_s = MW'(quo_q);
    if (num_neg_q) r_s = -r_s;
    p_s   = r_s * C_QUAD1;
    p_mag = p_s[MW-1] ? -p_s : p_s;
    d_s   = p_mag >>> FRAC_BITS;
    if (p_s[MW-1]) d_s = -d_s;
    ang_s = (x_neg_q ? C_QUAD3 : C_QUAD1) - d_s;
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    div_d      = div_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    num_neg_d  = num_neg_q;
    x_neg_d    = x_neg_q;
    y_neg_d    = y_neg_q;
    tag_d      = tag_q;
    out_tag_d  = out_tag_q;
    out_din_d  = out_din_q;
    in_y_rd_en = 1'b0;
    in_x_rd_en = 1'b0;
    out_wr_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!in_y_empty && !in_x_empty) begin
          in_y_rd_en = 1'b1;
          in_x_rd_en = 1'b1;
          rem_d      = {sum_mag, {FRAC_BITS{1'b0}}};
          div_d      = {den, {FRAC_BITS{1'b0}}};
          quo_d      = '0;
          cnt_d      = CW'(FRAC_BITS);
          num_neg_d  = sum[W-1];
          x_neg_d    = x_ext[W-1];
          y_neg_d    = y_ext[W-1];
          tag_d      = in_tag;
          state_d    = S_DIV;
        end
      end
      S_DIV: begin
        // Quotient is known to fit in FRAC_BITS+1 bits, so start at den<<FRAC_BITS.
        if (rem_q >= div_q) begin
          rem_d = rem_q - div_q;
          quo_d = {quo_q[QW-2:0], 1'b1};
        end else begin
          quo_d = {quo_q[QW-2:0], 1'b0};
        end
        div_d = div_q >> 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_SCALE;
      end
      S_SCALE: begin
        out_din_d = DATA_WIDTH'(y_neg_q ? -ang_s : ang_s);
        out_tag_d = tag_q;
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (!out_full) begin
          out_wr_en = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (reset) begin
      in_y_rd_en = 1'b0;
      in_x_rd_en = 1'b0;
      out_wr_en  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      div_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      num_neg_q <= 1'b0;
      x_neg_q   <= 1'b0;
      y_neg_q   <= 1'b0;
      tag_q     <= '0;
      out_tag_q <= '0;
      out_din_q <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      num_neg_q <= num_neg_d;
      x_neg_q   <= x_neg_d;
      y_neg_q   <= y_neg_d;
      tag_q     <= tag_d;
      out_tag_q <= out_tag_d;
      out_din_q <= out_din_d;
    end
  end

  assign out_din = out_din_q;
  assign out_tag = out_tag_q;
  assign busy    = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_qarctan_iter.sv
`default_nettype none
// tb_qarctan_iter: FIFO-model scoreboard bench for qarctan_iter at default parameters.
module tb_qarctan_iter;

  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_y_rd_en, in_x_rd_en, out_wr_en, busy;
  logic          in_y_empty, in_x_empty, out_full;
  logic [DW-1:0] in_y_dout, in_x_dout, out_din;
  logic [0:0]    in_tag, out_tag;

  qarctan_iter #(
    .DATA_WIDTH(32), .FRAC_BITS(10), .QUAD1(804), .QUAD3(2412), .TAG_WIDTH(1)
  ) dut (
    .clock(clock), .reset(reset),
    .in_y_rd_en(in_y_rd_en), .in_y_empty(in_y_empty), .in_y_dout(in_y_dout),
    .in_x_rd_en(in_x_rd_en), .in_x_empty(in_x_empty), .in_x_dout(in_x_dout),
    .in_tag(in_tag),
    .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din), .out_tag(out_tag),
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic signed [DW-1:0] ang;
    logic [0:0]           tag;
    int                   pcyc;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] yq[$];
  logic [DW-1:0] xq[$];
  logic [0:0]    tq[$];
  int            n_checks = 0, n_pass = 0;
  int            cyc = 0, last_push_cyc = 0, last_lat = 0, n_push = 0, n_stream = 0;
  logic [DW-1:0] last_din = '0;
  logic [0:0]    last_tag = '0;
  bit            stream_mode = 1'b0;
  bit            pop_pend = 1'b0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  // C reference: integer division truncates toward zero.
  function automatic logic signed [DW-1:0] ref_angle(input logic signed [DW-1:0] y,
                                                     input logic signed [DW-1:0] x);
    longint ly, lx, ay, num, den, r, p, d, ang;
    ly = longint'(y);
    lx = longint'(x);
    ay = (ly < 0 ? -ly : ly) + 1;
    if (lx >= 0) begin
      num = (lx - ay) * 1024;
      den = lx + ay;
    end else begin
      num = (lx + ay) * 1024;
      den = ay - lx;
    end
    r   = num / den;
    p   = 804 * r;
    d   = p / 1024;
    ang = (lx < 0 ? 2412 : 804) - d;
    if (ly < 0) ang = -ang;
    return ang[DW-1:0];
  endfunction

  task automatic refresh();
    in_y_empty = (yq.size() == 0);
    in_x_empty = (xq.size() == 0);
    in_y_dout  = (yq.size() != 0) ? yq[0] : '0;
    in_x_dout  = (xq.size() != 0) ? xq[0] : '0;
    in_tag     = (tq.size() != 0) ? tq[0] : '0;
  endtask

  task automatic push_pair(input logic [DW-1:0] y, input logic [DW-1:0] x, input logic [0:0] t);
    yq.push_back(y);
    xq.push_back(x);
    tq.push_back(t);
    refresh();
  endtask

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_rd(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      if (in_y_rd_en) seen = 1'b1;
    end
    if (!seen) check_val(tag, 0, 1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clock);
      if (sb.size() == 0 && yq.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) check_val(tag, 0, 1);
  endtask

  // Monitor: score pops and pushes at the falling edge; FIFO pops take effect after the rising edge.
  always begin
    @(negedge clock);
    cyc++;
    if (in_y_rd_en || in_x_rd_en) begin
      check_val("rd_pair", in_x_rd_en, in_y_rd_en);
      if (in_y_rd_en && in_x_rd_en) begin
        mon_e.ang  = ref_angle(in_y_dout, in_x_dout);
        mon_e.tag  = in_tag;
        mon_e.pcyc = cyc;
        sb.push_back(mon_e);
        pop_pend = 1'b1;
      end
    end
    if (out_wr_en) begin
      n_push++;
      if (sb.size() == 0) begin
        check_val("spurious_push", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check_val("angle", $signed(out_din), mon_e.ang);
        check_val("tag", out_tag, mon_e.tag);
        last_lat = cyc - mon_e.pcyc;
      end
      if (stream_mode) begin
        if (n_stream > 0) check_val("gap", cyc - last_push_cyc, 14);
        n_stream++;
      end
      last_push_cyc = cyc;
      last_din      = out_din;
      last_tag      = out_tag;
    end
    @(posedge clock);
    #1;
    if (pop_pend) begin
      void'(yq.pop_front());
      void'(xq.pop_front());
      void'(tq.pop_front());
      pop_pend = 1'b0;
      refresh();
    end
  end

  logic signed [DW-1:0] dy [5] = '{0, 100, -100, 0, 50};
  logic signed [DW-1:0] dx [5] = '{100, 0, 0, -100, 50};
  logic signed [DW-1:0] de [5] = '{17, 1608, -1608, 3199, 811};
  logic        [0:0]    dt [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int rd_cnt, wr_cnt, chg, base_push;
    logic [DW-1:0] held;
    out_full = 1'b0;
    refresh();
    // First directed pair waits in the FIFOs while reset is held.
    push_pair(dy[0], dx[0], dt[0]);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_val("rst_busy", busy, 0);
    check_val("rst_din", out_din, 0);
    check_val("rst_tag", out_tag, 0);
    check_val("rst_wr", out_wr_en, 0);
    check_val("rst_rd", in_y_rd_en, 0);
    sync();
    reset = 1'b0;

    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        sync();
        push_pair(dy[k], dx[k], dt[k]);
      end
      wait_drain("dir_timeout", 100);
      check_val($sformatf("dir%0d_angle", k), $signed(last_din), de[k]);
      check_val($sformatf("dir%0d_tag", k), last_tag, dt[k]);
      if (k == 0) check_val("latency", last_lat, 13);
    end

    // Streaming with both FIFOs holding all 64 pairs up front.
    n_stream    = 0;
    stream_mode = 1'b1;
    sync();
    for (int i = 0; i < 64; i++) begin
      if (i % 2 == 0) push_pair($urandom, $urandom, 1'($urandom_range(0, 1)));
      else push_pair(DW'($urandom_range(0, 2000)) - 32'd1000,
                     DW'($urandom_range(0, 2000)) - 32'd1000, 1'($urandom_range(0, 1)));
    end
    wait_drain("stream_timeout", 64 * 14 + 100);
    stream_mode = 1'b0;
    check_val("stream_count", n_stream, 64);

    // Back-pressure held through S_OUT with a second pair already waiting.
    base_push = n_push;
    sync();
    out_full = 1'b1;
    push_pair(32'd123, -32'd456, 1'b1);
    push_pair(-32'd789, 32'd321, 1'b0);
    wait_rd("hold_pop");
    repeat (13) @(negedge clock);
    held   = out_din;
    rd_cnt = 0;
    wr_cnt = 0;
    chg    = 0;
    repeat (40) begin
      @(negedge clock);
      if (in_y_rd_en || in_x_rd_en) rd_cnt++;
      if (out_wr_en) wr_cnt++;
      if (out_din != held) chg++;
    end
    check_val("hold_rd", rd_cnt, 0);
    check_val("hold_wr", wr_cnt, 0);
    check_val("hold_din_stable", chg, 0);
    check_val("hold_busy", busy, 1);
    sync();
    out_full = 1'b0;
    @(negedge clock);
    check_val("hold_push", out_wr_en, 1);
    check_val("hold_push_din", out_din, held);
    @(negedge clock);
    check_val("hold_next_pop", in_y_rd_en, 1);
    wait_drain("hold_timeout", 100);
    check_val("hold_push_count", n_push - base_push, 2);

    // Extremes.
    sync();
    push_pair(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_drain("ext1_timeout", 100);
    check_val("ext1_range", ($signed(last_din) >= -3217 && $signed(last_din) <= 3217), 1);
    sync();
    push_pair(32'h7fff_ffff, 32'd0, 1'b1);
    wait_drain("ext2_timeout", 100);
    check_val("ext2_angle", $signed(last_din), 1608);

    // Only the x FIFO has data.
    sync();
    xq.push_back(32'd1234);
    refresh();
    rd_cnt = 0;
    repeat (20) begin
      @(negedge clock);
      if (in_y_rd_en || in_x_rd_en) rd_cnt++;
    end
    check_val("onlyx_rd", rd_cnt, 0);
    check_val("onlyx_busy", busy, 0);
    sync();
    yq.push_back(-32'd567);
    tq.push_back(1'b1);
    refresh();
    wait_rd("onlyx_pop");
    check_val("onlyx_pair", in_x_rd_en, 1);
    wait_drain("onlyx_timeout", 100);

    // Reset in the fifth S_DIV cycle discards the sample in flight.
    sync();
    push_pair(32'd300, -32'd200, 1'b1);
    wait_rd("rst_pop");
    base_push = n_push;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_din", out_din, 0);
    check_val("mid_rst_tag", out_tag, 0);
    check_val("mid_rst_wr", out_wr_en, 0);
    sb.delete();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check_val("mid_rst_nopush", n_push - base_push, 0);
    sync();
    push_pair(-32'd700, 32'd250, 1'b0);
    wait_drain("mid_rst_timeout", 100);
    check_val("mid_rst_recover", n_push - base_push, 1);
    check_val("mid_rst_angle", $signed(last_din), ref_angle(-32'd700, 32'd250));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
